// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, register
// index constants and the bundle of stage-control enables.
package hazard_control_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic pipe_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1,
                                   ifid_flush: 1'b1, pipe_freeze: 1'b0};
  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0,
                                    ifid_flush: 1'b0, pipe_freeze: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b0,
                                    ifid_flush: 1'b0, pipe_freeze: 1'b1};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b1,
                                   ifid_flush: 1'b1, pipe_freeze: 1'b0};
  localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1,
                                   ifid_flush: 1'b0, pipe_freeze: 1'b0};

endpackage

// File: rtl/hazard_control_unit_reg_match.sv
// Register-index comparator: true when the producer register equals the
// consumer register and is not the hard-wired zero register.
module hazard_control_unit_reg_match
  import hazard_control_unit_pkg::*;
(
  input  logic [REG_W-1:0] prod_i,
  input  logic [REG_W-1:0] cons_i,
  output logic             match_o
);

  assign match_o = (prod_i == cons_i) && (prod_i != REG_ZERO);

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, taken
// branch flushes, data-memory wait freeze with timeout, and perf counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             ex_br_taken_i,
  input  logic             exmem_memacc_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_bubble_o,
  output logic             ifid_flush_o,
  output logic             pipe_freeze_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int WCNT_W = 16;
  localparam logic [WCNT_W-1:0] WAIT_LIMIT_C = WCNT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic  rs_hit_s, rt_hit_s;
  logic  lu_s, ms_s;
  logic  run_decode_s, lu_stall_s, br_flush_s;
  ctrl_t ctrl_s;

  hazard_control_unit_reg_match u_rs_match (
    .prod_i  (idex_rt_i),
    .cons_i  (ifid_rs_i),
    .match_o (rs_hit_s)
  );

  hazard_control_unit_reg_match u_rt_match (
    .prod_i  (idex_rt_i),
    .cons_i  (ifid_rt_i),
    .match_o (rt_hit_s)
  );

  assign lu_s = idex_memread_i & (rs_hit_s | (ifid_uses_rt_i & rt_hit_s));
  assign ms_s = exmem_memacc_i & ~dmem_ready_i;

  // FSM next state, wait counter and Mealy stage-control decode
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    ctrl_s        = CTRL_NORMAL;
    run_decode_s  = 1'b0;
    lu_stall_s    = 1'b0;
    br_flush_s    = 1'b0;
    case (state_q)
      ST_RUN: begin
        run_decode_s = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (dmem_ready_i) begin
          run_decode_s = 1'b1;
          state_d      = ST_RUN;
          wait_cnt_d   = 16'd0;
        end else begin
          ctrl_s     = CTRL_FREEZE;
          wait_cnt_d = wait_cnt_q + 16'd1;
          if (wait_cnt_q == WAIT_LIMIT_C) begin
            state_d       = ST_TIMEOUT;
            mem_timeout_d = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end
      end
      ST_TIMEOUT: begin
        ctrl_s = CTRL_FREEZE;
      end
      default: begin
        ctrl_s  = CTRL_FREEZE;
        state_d = ST_RUN;
      end
    endcase

    // Frozen stage registers re-present any branch or load-use on release
    if (run_decode_s) begin
      if (ms_s) begin
        ctrl_s     = CTRL_FREEZE;
        state_d    = ST_MEM_WAIT;
        wait_cnt_d = 16'd1;
      end else if (ex_br_taken_i) begin
        ctrl_s     = CTRL_FLUSH;
        br_flush_s = 1'b1;
      end else if (lu_s) begin
        ctrl_s     = CTRL_STALL;
        lu_stall_s = 1'b1;
      end else begin
        ctrl_s = CTRL_NORMAL;
      end
    end else begin
      run_decode_s = 1'b0;
    end

    if (reset_i) begin
      ctrl_s        = CTRL_RESET;
      state_d       = ST_RUN;
      wait_cnt_d    = 16'd0;
      mem_timeout_d = 1'b0;
    end else begin
      mem_timeout_d = mem_timeout_d;
    end
  end

  // Saturating perf counters
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if ((ctrl_s.pipe_freeze | lu_stall_s) && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1'b1);
    end else begin
      stall_count_d = stall_count_q;
    end
    if (br_flush_s && (flush_count_q != CNT_MAX)) begin
      flush_count_d = flush_count_q + CNT_W'(1'b1);
    end else begin
      flush_count_d = flush_count_q;
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= {CNT_W{1'b0}};
      flush_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign pc_write_o    = ctrl_s.pc_write;
  assign ifid_write_o  = ctrl_s.ifid_write;
  assign idex_bubble_o = ctrl_s.idex_bubble;
  assign ifid_flush_o  = ctrl_s.ifid_flush;
  assign pipe_freeze_o = ctrl_s.pipe_freeze;
  assign mem_timeout_o = mem_timeout_q;
  assign stall_count_o = stall_count_q;
  assign flush_count_o = flush_count_q;

endmodule
